// File: rtl/ub_mac_scheduler.sv
// Round-robin job scheduler that shares one unary-binary MAC (out = a*b + c) among NREQ requesters.
// One job is in flight at a time: accept, pulse the MAC, wait out the stream window, return the result.
module ub_mac_scheduler #(
    parameter int SIZE       = 4,
    parameter int NREQ       = 4,
    parameter int RUN_CYCLES = (1 << SIZE) + 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*SIZE-1:0]     req_a,
    input  logic [NREQ*SIZE-1:0]     req_b,
    input  logic [NREQ*SIZE-1:0]     req_c,
    output logic                     mac_valid,
    output logic [SIZE-1:0]          mac_a,
    output logic [SIZE-1:0]          mac_b,
    output logic [SIZE-1:0]          mac_c,
    input  logic [2*SIZE-1:0]        mac_out,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [$clog2(NREQ)-1:0]  resp_id,
    output logic [2*SIZE-1:0]        resp_data,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(RUN_CYCLES + 1);
    localparam int DW  = 2 * SIZE;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RUN,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rrPtr_q, rrPtr_d;
    logic [CW-1:0]     runCnt_q, runCnt_d;
    logic [SIZE-1:0]   macA_q, macA_d;
    logic [SIZE-1:0]   macB_q, macB_d;
    logic [SIZE-1:0]   macC_q, macC_d;
    logic [IDW-1:0]    respId_q, respId_d;
    logic [DW-1:0]     respData_q, respData_d;

    logic              anyReq;
    logic [IDW-1:0]    grantIdx;
    logic [IDW:0]      cand;
    logic              runDone;

    // Search upward from rrPtr with wrap; the first pending requester wins.
    always_comb begin
        anyReq   = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rrPtr_q} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!anyReq && req_valid[cand[IDW-1:0]]) begin
                anyReq   = 1'b1;
                grantIdx = cand[IDW-1:0];
            end
        end
    end

    assign req_ready = (state_q == IDLE && anyReq && reset_n) ? (NREQ'(1) << grantIdx) : '0;
    assign runDone   = (runCnt_q == CW'(RUN_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        runCnt_d   = runCnt_q;
        macA_d     = macA_q;
        macB_d     = macB_q;
        macC_d     = macC_q;
        respId_d   = respId_q;
        respData_d = respData_q;
        unique case (state_q)
            IDLE: begin
                if (anyReq) begin
                    macA_d   = req_a[int'(grantIdx)*SIZE +: SIZE];
                    macB_d   = req_b[int'(grantIdx)*SIZE +: SIZE];
                    macC_d   = req_c[int'(grantIdx)*SIZE +: SIZE];
                    respId_d = grantIdx;
                    rrPtr_d  = (grantIdx == IDW'(NREQ - 1)) ? '0 : grantIdx + 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                runCnt_d = '0;
                state_d  = RUN;
            end
            RUN: begin
                runCnt_d = runCnt_q + 1'b1;
                if (runDone) begin
                    respData_d = mac_out;
                    state_d    = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset discards any in-flight job and restarts arbitration from requester 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            runCnt_q   <= '0;
            macA_q     <= '0;
            macB_q     <= '0;
            macC_q     <= '0;
            respId_q   <= '0;
            respData_q <= '0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            runCnt_q   <= runCnt_d;
            macA_q     <= macA_d;
            macB_q     <= macB_d;
            macC_q     <= macC_d;
            respId_q   <= respId_d;
            respData_q <= respData_d;
        end
    end

    assign mac_valid  = (state_q == ISSUE);
    assign resp_valid = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign mac_a      = macA_q;
    assign mac_b      = macB_q;
    assign mac_c      = macC_q;
    assign resp_id    = respId_q;
    assign resp_data  = respData_q;

endmodule

// File: tb/tb_ub_mac_scheduler.sv
// Bench for ub_mac_scheduler: a MAC model whose result only settles after the stream window,
// and a round-robin reference model that predicts grants, latencies and returned data.
module tb_ub_mac_scheduler;

    localparam int SIZE = 4;
    localparam int NREQ = 4;
    localparam int RC   = (1 << SIZE) + 2;
    localparam int DW   = 2 * SIZE;
    localparam int IDW  = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*SIZE-1:0]  req_a, req_b, req_c;
    logic                  mac_valid;
    logic [SIZE-1:0]       mac_a, mac_b, mac_c;
    logic [DW-1:0]         mac_out;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [DW-1:0]         resp_data;
    logic                  busy;

    logic [SIZE-1:0]       opA [NREQ];
    logic [SIZE-1:0]       opB [NREQ];
    logic [SIZE-1:0]       opC [NREQ];
    int                    modelPtr;
    int                    assertCount = 0;
    int                    failCount = 0;

    logic [7:0]            macAge;
    logic [DW-1:0]         macTrue;

    ub_mac_scheduler #(.SIZE(SIZE), .NREQ(NREQ), .RUN_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_out(mac_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // MAC model: the result is only correct once the unary stream has run RC cycles past valid.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) macAge <= 8'd0;
        else if (mac_valid) macAge <= 8'd1;
        else if (macAge != 8'd0 && macAge != 8'hFF) macAge <= macAge + 8'd1;
    end
    assign macTrue = DW'(mac_a) * DW'(mac_b) + DW'(mac_c);
    assign mac_out = (macAge >= 8'(RC)) ? macTrue : ~macTrue;

    function automatic int modelPick(input logic [NREQ-1:0] mask, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (mask[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic driveOperands();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*SIZE +: SIZE] = opA[i];
            req_b[i*SIZE +: SIZE] = opB[i];
            req_c[i*SIZE +: SIZE] = opC[i];
        end
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        resp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelPtr = 0;
        #1;
    endtask

    task automatic waitGrant(input int maxCycles, output int idx, output int waited);
        bit found;
        idx = -1;
        waited = 0;
        found = 1'b0;
        #1;
        while (!found && waited <= maxCycles) begin
            if ((req_valid & req_ready) != '0) begin
                found = 1'b1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
            end else begin
                @(negedge clk); #1;
                waited++;
            end
        end
    endtask

    // One complete job: grant, issue pulse, stream window, response (optionally backpressured).
    task automatic runJob(input string name, input int expId, input int maxWait, input bit mustBeImmediate,
                          input logic [NREQ-1:0] nextMask, input int holdCycles, input bit perturb);
        int idx, waited;
        logic [SIZE-1:0] ea, eb, ec;
        logic [DW-1:0] ed;
        resp_ready = (holdCycles == 0);
        waitGrant(maxWait, idx, waited);
        assertCount++;
        if (idx != expId) begin
            failCount++;
            $display("[TB] FAIL %s grant: actual=%0d expected=%0d", name, idx, expId);
        end
        if (idx < 0) return;
        if (mustBeImmediate) begin
            assertCount++;
            if (waited != 0) begin
                failCount++;
                $display("[TB] FAIL %s grant delay: actual=%0d expected=0", name, waited);
            end
        end
        assertCount++;
        if ($countones(req_ready) != 1 || mac_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s accept cycle: req_ready=%b mac_valid=%b expected one-hot and 0", name, req_ready, mac_valid);
        end
        ea = opA[expId]; eb = opB[expId]; ec = opC[expId];
        ed = DW'(ea) * DW'(eb) + DW'(ec);
        modelPtr = (expId + 1) % NREQ;

        @(negedge clk); #1;
        req_valid = nextMask;
        assertCount++;
        if (mac_valid !== 1'b1 || busy !== 1'b1 || req_ready !== '0 || {mac_a, mac_b, mac_c} !== {ea, eb, ec}) begin
            failCount++;
            $display("[TB] FAIL %s issue: mac_valid=%b busy=%b req_ready=%b ops=%h expected 1 1 0 %h",
                     name, mac_valid, busy, req_ready, {mac_a, mac_b, mac_c}, {ea, eb, ec});
        end
        for (int k = 2; k <= RC + 1; k++) begin
            @(negedge clk); #1;
            if (perturb && k == 6) begin
                opA[expId] = ~ea; opB[expId] = ~eb; opC[expId] = ~ec;
                driveOperands();
                #1;
            end
            assertCount++;
            if (mac_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0 || busy !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL %s run cycle %0d: mac_valid=%b resp_valid=%b req_ready=%b busy=%b expected 0 0 0 1",
                         name, k, mac_valid, resp_valid, req_ready, busy);
            end
            assertCount++;
            if ({mac_a, mac_b, mac_c} !== {ea, eb, ec}) begin
                failCount++;
                $display("[TB] FAIL %s operand hold cycle %0d: actual=%h expected=%h", name, k, {mac_a, mac_b, mac_c}, {ea, eb, ec});
            end
        end

        @(negedge clk); #1;
        assertCount++;
        if (resp_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s resp latency: resp_valid=%b expected 1 at accept+%0d", name, resp_valid, RC + 2);
        end
        assertCount++;
        if (resp_id !== IDW'(expId) || resp_data !== ed) begin
            failCount++;
            $display("[TB] FAIL %s resp: id=%0d data=%0d expected id=%0d data=%0d", name, resp_id, resp_data, expId, ed);
        end
        for (int h = 1; h < holdCycles; h++) begin
            @(negedge clk); #1;
            assertCount++;
            if (resp_valid !== 1'b1 || resp_id !== IDW'(expId) || resp_data !== ed || req_ready !== '0) begin
                failCount++;
                $display("[TB] FAIL %s backpressure cycle %0d: valid=%b id=%0d data=%0d req_ready=%b expected 1 %0d %0d 0",
                         name, h, resp_valid, resp_id, resp_data, req_ready, expId, ed);
            end
        end
        if (holdCycles > 0) begin
            @(negedge clk); #1;
            resp_ready = 1'b1;
        end
        @(negedge clk); #1;
        assertCount++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s return to idle: busy=%b resp_valid=%b expected 0 0", name, busy, resp_valid);
        end
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset_n = 1'b0;
        resp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            opA[i] = 4'(i + 1); opB[i] = 4'(i + 2); opC[i] = 4'(i + 3);
        end
        driveOperands();
        @(negedge clk); #1;
        assertCount++;
        if (req_ready !== '0 || busy !== 1'b0 || mac_valid !== 1'b0 || resp_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset controls: req_ready=%b busy=%b mac_valid=%b resp_valid=%b expected all 0",
                     req_ready, busy, mac_valid, resp_valid);
        end
        assertCount++;
        if ({mac_a, mac_b, mac_c} !== '0 || resp_id !== '0 || resp_data !== '0) begin
            failCount++;
            $display("[TB] FAIL reset data: ops=%h id=%0d data=%0d expected 0", {mac_a, mac_b, mac_c}, resp_id, resp_data);
        end
        req_valid = '0;
        @(negedge clk);
        reset_n = 1'b1;
        modelPtr = 0;
        #1;
        assertCount++;
        if (busy !== 1'b0 || req_ready !== '0) begin
            failCount++;
            $display("[TB] FAIL reset idle: busy=%b req_ready=%b expected 0 0", busy, req_ready);
        end
    endtask

    task automatic test_single_job();
        $display("[TB] test_single_job");
        doReset();
        opA[2] = 4'd3; opB[2] = 4'd5; opC[2] = 4'd2;
        driveOperands();
        req_valid = 4'b0100;
        runJob("single_job", 2, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_round_robin();
        $display("[TB] test_round_robin");
        doReset();
        req_valid = 4'b1111;
        runJob("rr0", 0, 3, 1'b1, 4'b1111, 0, 1'b0);
        runJob("rr1", 1, 3, 1'b1, 4'b1111, 0, 1'b0);
        runJob("rr2", 2, 3, 1'b1, 4'b1111, 0, 1'b0);
        runJob("rr3", 3, 3, 1'b1, 4'b1111, 0, 1'b0);
        runJob("rr4", 0, 3, 1'b1, 4'b1111, 0, 1'b0);
        runJob("rr5", 1, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_skip_wrap();
        $display("[TB] test_skip_wrap");
        doReset();
        req_valid = 4'b0100;
        runJob("wrap_first", 2, 3, 1'b1, 4'b1010, 0, 1'b0);
        runJob("wrap_skip", 3, 3, 1'b1, 4'b0010, 0, 1'b0);
        runJob("wrap_around", 1, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        $display("[TB] test_backpressure");
        doReset();
        opA[1] = 4'd7; opB[1] = 4'd6; opC[1] = 4'd9;
        driveOperands();
        req_valid = 4'b0010;
        runJob("bp_hold", 1, 3, 1'b1, 4'b0001, 10, 1'b0);
        runJob("bp_next", 0, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_operand_stability();
        $display("[TB] test_operand_stability");
        doReset();
        opA[1] = 4'd5; opB[1] = 4'd9; opC[1] = 4'd3;
        driveOperands();
        req_valid = 4'b0010;
        runJob("stable_hold", 1, 3, 1'b1, 4'b0010, 0, 1'b1);
        runJob("stable_relatch", 1, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int idx, waited;
        $display("[TB] test_reset_mid_run");
        doReset();
        opA[2] = 4'd9; opB[2] = 4'd11; opC[2] = 4'd4;
        opA[1] = 4'd2; opB[1] = 4'd13; opC[1] = 4'd1;
        driveOperands();
        req_valid = 4'b0100;
        runJob("pre_reset", 2, 3, 1'b1, 4'b0010, 0, 1'b0);
        waitGrant(3, idx, waited);
        assertCount++;
        if (idx != 1) begin
            failCount++;
            $display("[TB] FAIL mid_run grant: actual=%0d expected=1", idx);
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk); #1;
            if (k == 1) req_valid = 4'b1001;
        end
        assertCount++;
        if (busy !== 1'b1 || resp_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_run before reset: busy=%b resp_valid=%b expected 1 0", busy, resp_valid);
        end
        reset_n = 1'b0;
        #1;
        assertCount++;
        if (busy !== 1'b0 || mac_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0) begin
            failCount++;
            $display("[TB] FAIL mid_run reset controls: busy=%b mac_valid=%b resp_valid=%b req_ready=%b expected all 0",
                     busy, mac_valid, resp_valid, req_ready);
        end
        assertCount++;
        if ({mac_a, mac_b, mac_c} !== '0 || resp_id !== '0 || resp_data !== '0) begin
            failCount++;
            $display("[TB] FAIL mid_run reset data: ops=%h id=%0d data=%0d expected 0", {mac_a, mac_b, mac_c}, resp_id, resp_data);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        modelPtr = 0;
        for (int k = 0; k < RC + 6; k++) begin
            @(negedge clk); #1;
            assertCount++;
            if (resp_valid !== 1'b0 || busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL mid_run discarded job cycle %0d: resp_valid=%b busy=%b expected 0 0", k, resp_valid, busy);
            end
        end
        req_valid = 4'b1001;
        runJob("post_reset", 0, 3, 1'b1, 4'b0000, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0] mask;
        int expId;
        $display("[TB] test_random");
        doReset();
        for (int j = 0; j < 20; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                opA[i] = 4'($urandom_range(0, 15));
                opB[i] = 4'($urandom_range(0, 15));
                opC[i] = 4'($urandom_range(0, 15));
            end
            driveOperands();
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_valid = mask;
            expId = modelPick(mask, modelPtr);
            runJob("random", expId, 3, 1'b1, 4'b0000, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_skip_wrap();
        test_backpressure();
        test_operand_stability();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: actual=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
